// File: rtl/pattern_stream_counter.sv
// Streaming pattern matcher with method-style EN_/RDY_ handshakes: start() loads a
// pattern, each next() consumes one symbol and returns {match, running count}, stop() ends.
module pattern_stream_counter #(
    parameter int unsigned K_W     = 1,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned OVERLAP = 1,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [MAX_LEN*K_W-1:0] start_pat,
    input  logic [LEN_W-1:0]       start_len,
    input  logic                   EN_start,
    output logic                   RDY_start,
    input  logic [K_W-1:0]         next_k,
    input  logic                   EN_next,
    output logic [CNT_W:0]         next,
    output logic                   RDY_next,
    input  logic                   EN_stop,
    output logic                   RDY_stop,
    output logic [CNT_W-1:0]       count_out
);

    // Only MAX_LEN-1 past symbols are stored; the incoming next_k completes the window.
    localparam int unsigned HD = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [HD*K_W-1:0]      hist_q, hist_d;
    logic [MAX_LEN*K_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       fill_q, fill_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [(HD+1)*K_W-1:0]  window;
    logic                   pat_eq;
    logic                   fill_ok;
    logic                   hit;
    logic                   cnt_sat;
    logic [CNT_W-1:0]       count_upd;

    // Symbol 0 of the window is the newest (next_k); pattern symbol len-1 is the newest.
    assign window = {hist_q, next_k};

    always_comb begin : match_c
        pat_eq = 1'b1;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(len_q)) begin
                if (pat_q[i*K_W +: K_W] != window[(32'(len_q) - 1 - i)*K_W +: K_W]) begin
                    pat_eq = 1'b0;
                end
            end
        end
    end

    assign fill_ok   = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    assign hit       = (state_q == RUN) && (len_q != '0) && fill_ok && pat_eq;
    assign cnt_sat   = &count_q;
    assign count_upd = count_q + CNT_W'(hit && !cnt_sat);

    assign next      = (state_q == RUN) ? {hit, count_upd} : '0;
    assign RDY_start = (state_q == IDLE);
    assign RDY_next  = (state_q == RUN);
    assign RDY_stop  = (state_q == RUN);
    assign count_out = count_q;

    always_comb begin : fsm_c
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (EN_start) begin
                    state_d = RUN;
                    pat_d   = start_pat;
                    len_d   = (start_len > MAX_LEN_L) ? MAX_LEN_L : start_len;
                    hist_d  = '0;
                    fill_d  = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                // stop has priority; a simultaneous next() symbol is dropped
                if (EN_stop) begin
                    state_d = IDLE;
                end else if (EN_next) begin
                    hist_d  = window[HD*K_W-1:0];
                    fill_d  = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
                    count_d = count_upd;
                    if (OVERLAP == 0 && hit) begin
                        hist_d = '0;
                        fill_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            hist_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pattern_stream_counter.sv
// Directed bench: three instances (overlapping, non-overlapping, 2-bit counter) share stimulus.
module tb_pattern_stream_counter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] start_pat = '0;
    logic [3:0] start_len = '0;
    logic       EN_start = 1'b0;
    logic       next_k = 1'b0;
    logic       EN_next = 1'b0;
    logic       EN_stop = 1'b0;

    logic       rdy_start_a, rdy_next_a, rdy_stop_a;
    logic [8:0] next_a;
    logic [7:0] count_out_a;
    logic       rdy_start_b, rdy_next_b, rdy_stop_b;
    logic [8:0] next_b;
    logic [7:0] count_out_b;
    logic       rdy_start_c, rdy_next_c, rdy_stop_c;
    logic [2:0] next_c;
    logic [1:0] count_out_c;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pattern_stream_counter #(.K_W(1), .MAX_LEN(8), .CNT_W(8), .OVERLAP(1)) dut_a (
        .CLK(CLK), .RST(RST), .start_pat(start_pat), .start_len(start_len),
        .EN_start(EN_start), .RDY_start(rdy_start_a), .next_k(next_k), .EN_next(EN_next),
        .next(next_a), .RDY_next(rdy_next_a), .EN_stop(EN_stop), .RDY_stop(rdy_stop_a),
        .count_out(count_out_a)
    );

    pattern_stream_counter #(.K_W(1), .MAX_LEN(8), .CNT_W(8), .OVERLAP(0)) dut_b (
        .CLK(CLK), .RST(RST), .start_pat(start_pat), .start_len(start_len),
        .EN_start(EN_start), .RDY_start(rdy_start_b), .next_k(next_k), .EN_next(EN_next),
        .next(next_b), .RDY_next(rdy_next_b), .EN_stop(EN_stop), .RDY_stop(rdy_stop_b),
        .count_out(count_out_b)
    );

    pattern_stream_counter #(.K_W(1), .MAX_LEN(8), .CNT_W(2), .OVERLAP(1)) dut_c (
        .CLK(CLK), .RST(RST), .start_pat(start_pat), .start_len(start_len),
        .EN_start(EN_start), .RDY_start(rdy_start_c), .next_k(next_k), .EN_next(EN_next),
        .next(next_c), .RDY_next(rdy_next_c), .EN_stop(EN_stop), .RDY_stop(rdy_stop_c),
        .count_out(count_out_c)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [7:0] pat, input logic [3:0] len);
        start_pat = pat;
        start_len = len;
        EN_start  = 1'b1;
        tick();
        EN_start  = 1'b0;
    endtask

    task automatic do_stop();
        EN_stop = 1'b1;
        tick();
        EN_stop = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        total++;
        if (rdy_start_a !== 1'b1) begin bad++; $display("FAIL reset_rdy_start got=%0b want=1", rdy_start_a); end
        total++;
        if (rdy_next_a !== 1'b0) begin bad++; $display("FAIL reset_rdy_next got=%0b want=0", rdy_next_a); end
        total++;
        if (rdy_stop_a !== 1'b0) begin bad++; $display("FAIL reset_rdy_stop got=%0b want=0", rdy_stop_a); end
        total++;
        if (count_out_a !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_out_a); end
        total++;
        if (next_a !== 9'd0) begin bad++; $display("FAIL reset_next got=%h want=0", next_a); end
    endtask

    task automatic test_overlap();
        logic [4:0] stream = 5'b10101;
        int hit_a[5] = '{0, 0, 1, 0, 1};
        int cnt_a[5] = '{0, 0, 1, 1, 2};
        int hit_b[5] = '{0, 0, 1, 0, 0};
        int cnt_b[5] = '{0, 0, 1, 1, 1};
        logic [8:0] exp_a, exp_b;
        do_start(8'b0000_0101, 4'd3);
        total++;
        if (rdy_next_a !== 1'b1) begin bad++; $display("FAIL start_rdy_next got=%0b want=1", rdy_next_a); end
        for (int i = 0; i < 5; i++) begin
            next_k  = stream[i];
            EN_next = 1'b1;
            #1;
            exp_a = {1'(hit_a[i]), 8'(cnt_a[i])};
            exp_b = {1'(hit_b[i]), 8'(cnt_b[i])};
            total++;
            if (next_a !== exp_a) begin bad++; $display("FAIL overlap_next[%0d] got=%h want=%h", i, next_a, exp_a); end
            total++;
            if (next_b !== exp_b) begin bad++; $display("FAIL nooverlap_next[%0d] got=%h want=%h", i, next_b, exp_b); end
            tick();
        end
        EN_next = 1'b0;
        total++;
        if (count_out_a !== 8'd2) begin bad++; $display("FAIL overlap_count got=%0d want=2", count_out_a); end
        total++;
        if (count_out_b !== 8'd1) begin bad++; $display("FAIL nooverlap_count got=%0d want=1", count_out_b); end
        do_stop();
        total++;
        if (rdy_start_a !== 1'b1 || rdy_next_a !== 1'b0) begin
            bad++; $display("FAIL stop_state got=%0b%0b want=10", rdy_start_a, rdy_next_a);
        end
        total++;
        if (count_out_a !== 8'd2) begin bad++; $display("FAIL stop_hold_count got=%0d want=2", count_out_a); end
    endtask

    task automatic test_order();
        // pattern oldest..newest = 1,1,0 ; stream 0,1,1,0
        logic [3:0] stream = 4'b0110;
        int hit_a[4] = '{0, 0, 0, 1};
        logic [8:0] exp_a;
        do_start(8'b0000_0011, 4'd3);
        for (int i = 0; i < 4; i++) begin
            next_k  = stream[i];
            EN_next = 1'b1;
            #1;
            exp_a = {1'(hit_a[i]), 8'(hit_a[i])};
            total++;
            if (next_a !== exp_a) begin bad++; $display("FAIL order_next[%0d] got=%h want=%h", i, next_a, exp_a); end
            tick();
        end
        EN_next = 1'b0;
        do_stop();
    endtask

    task automatic test_saturate();
        int cnt_c[5] = '{1, 2, 3, 3, 3};
        logic [2:0] exp_c;
        do_start(8'h01, 4'd1);
        for (int i = 0; i < 5; i++) begin
            next_k  = 1'b1;
            EN_next = 1'b1;
            #1;
            exp_c = {1'b1, 2'(cnt_c[i])};
            total++;
            if (next_c !== exp_c) begin bad++; $display("FAIL sat_next[%0d] got=%b want=%b", i, next_c, exp_c); end
            tick();
            total++;
            if (count_out_c !== 2'(cnt_c[i])) begin
                bad++; $display("FAIL sat_count[%0d] got=%0d want=%0d", i, count_out_c, cnt_c[i]);
            end
        end
        EN_next = 1'b0;
        total++;
        if (count_out_a !== 8'd5) begin bad++; $display("FAIL len1_count got=%0d want=5", count_out_a); end
        total++;
        if (count_out_b !== 8'd5) begin bad++; $display("FAIL len1_nooverlap_count got=%0d want=5", count_out_b); end
        do_stop();
    endtask

    task automatic test_ignore();
        next_k  = 1'b1;
        EN_next = 1'b1;
        #1;
        total++;
        if (next_a !== 9'd0) begin bad++; $display("FAIL idle_next got=%h want=0", next_a); end
        tick();
        EN_next = 1'b0;
        total++;
        if (rdy_start_a !== 1'b1 || count_out_a !== 8'd5) begin
            bad++; $display("FAIL idle_en_next got=rdy%0b/%0d want=rdy1/5", rdy_start_a, count_out_a);
        end
        do_start(8'h01, 4'd1);
        total++;
        if (count_out_a !== 8'd0) begin bad++; $display("FAIL restart_count got=%0d want=0", count_out_a); end
        do_start(8'h00, 4'd1);
        total++;
        if (rdy_next_a !== 1'b1) begin bad++; $display("FAIL run_en_start got=%0b want=1", rdy_next_a); end
        next_k  = 1'b1;
        EN_next = 1'b1;
        #1;
        total++;
        if (next_a !== {1'b1, 8'd1}) begin bad++; $display("FAIL run_pattern_kept got=%h want=%h", next_a, {1'b1, 8'd1}); end
        tick();
        EN_stop = 1'b1;
        #1;
        total++;
        if (next_a !== {1'b1, 8'd2}) begin bad++; $display("FAIL stop_next_driven got=%h want=%h", next_a, {1'b1, 8'd2}); end
        tick();
        EN_stop = 1'b0;
        EN_next = 1'b0;
        total++;
        if (rdy_start_a !== 1'b1 || count_out_a !== 8'd1) begin
            bad++; $display("FAIL stop_wins got=rdy%0b/%0d want=rdy1/1", rdy_start_a, count_out_a);
        end
    endtask

    task automatic test_clamp_and_reset();
        logic [8:0] exp_a;
        do_start(8'hFF, 4'd12);
        for (int i = 0; i < 9; i++) begin
            next_k  = 1'b1;
            EN_next = 1'b1;
            #1;
            exp_a = (i < 7) ? 9'd0 : {1'b1, 8'(i - 6)};
            total++;
            if (next_a !== exp_a) begin bad++; $display("FAIL clamp_next[%0d] got=%h want=%h", i, next_a, exp_a); end
            tick();
        end
        EN_next = 1'b0;
        total++;
        if (count_out_a !== 8'd2) begin bad++; $display("FAIL clamp_count got=%0d want=2", count_out_a); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if (rdy_start_a !== 1'b1 || rdy_next_a !== 1'b0) begin
            bad++; $display("FAIL midrun_reset_state got=%0b%0b want=10", rdy_start_a, rdy_next_a);
        end
        total++;
        if (count_out_a !== 8'd0) begin bad++; $display("FAIL midrun_reset_count got=%0d want=0", count_out_a); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_order();
        test_saturate();
        test_ignore();
        test_clamp_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
